// File: rtl/data_pointer_unit.sv
// data_pointer_unit: tape pointer for the brainfuck core (MOVE / HOME commands, wrap or clamp).
// Define DPU_SCAN_EN to include the hardware [>]/[<] zero-cell scan.
module data_pointer_unit #(
    parameter int ADDR_W    = 10,
    parameter int MEM_DEPTH = 1024,
    parameter int STEP_W    = 8,
    parameter int CELL_W    = 8,
    parameter int SATURATE  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [STEP_W-1:0] cmd_off,
    input  logic              scan_abort,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] ptr,
    output logic              busy,
    output logic              done,
    output logic              err_bound,
    output logic              err_op,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [CELL_W-1:0] mem_rd_data
);

    localparam int SW = ADDR_W + 2;
    localparam logic signed [SW-1:0] DEPTH_S  = SW'(MEM_DEPTH);
    localparam logic signed [SW-1:0] DEPTH_M1 = SW'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        OP_MOVE = 2'b00,
        OP_SCAN = 2'b01,
        OP_HOME = 2'b10,
        OP_RSVD = 2'b11
    } op_t;

    // One correction step suffices for wrap because |step| never exceeds MEM_DEPTH.
    function automatic logic [ADDR_W-1:0] bound_fn(
        input  logic [ADDR_W-1:0] base,
        input  logic [STEP_W-1:0] step_in,
        output logic              clamp_out
    );
        logic signed [SW-1:0] sum;
        logic signed [SW-1:0] res;
        sum = $signed({2'b00, base}) + $signed({{(SW-STEP_W){step_in[STEP_W-1]}}, step_in});
        clamp_out = 1'b0;
        res = sum;
        if (SATURATE != 0) begin
            if (sum[SW-1]) begin
                res = '0;
                clamp_out = 1'b1;
            end else if (sum > DEPTH_M1) begin
                res = DEPTH_M1;
                clamp_out = 1'b1;
            end
        end else begin
            if (sum[SW-1])
                res = sum + DEPTH_S;
            else if (sum > DEPTH_M1)
                res = sum - DEPTH_S;
        end
        return ADDR_W'(res);
    endfunction

    logic [ADDR_W-1:0] ptr_q, ptr_d, nxt_ptr;
    logic [STEP_W-1:0] step;
    logic              clamp;
    logic              done_q, done_d;
    logic              set_bound, set_op;
    logic              err_bound_q, err_op_q;
    op_t               op;

`ifdef DPU_SCAN_EN
    typedef enum logic [1:0] {
        IDLE,
        S_RD,
        S_CHK
    } state_t;

    state_t            state_q, state_d;
    logic [STEP_W-1:0] off_q, off_d;

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign mem_rd_en = (state_q == S_RD);
`else
    logic unused_scan;

    assign cmd_ready   = 1'b1;
    assign busy        = 1'b0;
    assign mem_rd_en   = 1'b0;
    assign unused_scan = ^{scan_abort, mem_rd_data};
`endif

    assign op          = op_t'(cmd_op);
    assign ptr         = ptr_q;
    assign mem_rd_addr = ptr_q;
    assign done        = done_q;
    assign err_bound   = err_bound_q;
    assign err_op      = err_op_q;

    always_comb begin
        ptr_d     = ptr_q;
        done_d    = 1'b0;
        set_bound = 1'b0;
        set_op    = 1'b0;
`ifdef DPU_SCAN_EN
        state_d   = state_q;
        off_d     = off_q;
        step      = (state_q == IDLE) ? cmd_off : off_q;
`else
        step      = cmd_off;
`endif
        nxt_ptr = bound_fn(ptr_q, step, clamp);

        if (cmd_valid && cmd_ready) begin
            case (op)
                OP_MOVE: begin
                    ptr_d     = nxt_ptr;
                    set_bound = clamp;
                    done_d    = 1'b1;
                end
                OP_HOME: begin
                    ptr_d  = '0;
                    done_d = 1'b1;
                end
`ifdef DPU_SCAN_EN
                OP_SCAN: begin
                    off_d   = cmd_off;
                    state_d = S_RD;
                end
`endif
                default: begin
                    set_op = 1'b1;
                    done_d = 1'b1;
                end
            endcase
        end

`ifdef DPU_SCAN_EN
        case (state_q)
            S_RD: begin
                state_d = S_CHK;
                if (scan_abort) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            S_CHK: begin
                // Abort takes priority over the pending step, so ptr holds.
                if (scan_abort || (mem_rd_data == '0) || (off_q == '0)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    ptr_d = nxt_ptr;
                    if (clamp) begin
                        set_bound = 1'b1;
                        state_d   = IDLE;
                        done_d    = 1'b1;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            default: ;
        endcase
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            done_q      <= 1'b0;
            err_bound_q <= 1'b0;
            err_op_q    <= 1'b0;
`ifdef DPU_SCAN_EN
            state_q     <= IDLE;
            off_q       <= '0;
`endif
        end else begin
            ptr_q       <= ptr_d;
            done_q      <= done_d;
            err_bound_q <= set_bound | (err_bound_q & ~err_clr);
            err_op_q    <= set_op | (err_op_q & ~err_clr);
`ifdef DPU_SCAN_EN
            state_q     <= state_d;
            off_q       <= off_d;
`endif
        end
    end

endmodule

// File: tb/tb_data_pointer_unit.sv
// Directed bench for data_pointer_unit: a wrap-mode and a saturate-mode instance share stimulus.
module tb_data_pointer_unit;

    localparam int AW    = 10;
    localparam int STEP  = 8;
    localparam int CW    = 8;
    localparam int DEPTH = 1024;

    localparam logic [1:0] MOVE = 2'b00;
    localparam logic [1:0] SCAN = 2'b01;
    localparam logic [1:0] HOME = 2'b10;
    localparam logic [1:0] RSVD = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            cmd_valid;
    logic [1:0]      cmd_op;
    logic [STEP-1:0] cmd_off;
    logic            scan_abort;
    logic            err_clr;

    logic            rdy_w, busy_w, done_w, eb_w, eop_w, rd_w;
    logic [AW-1:0]   ptr_w, addr_w;
    logic [CW-1:0]   rdata_w;
    logic            rdy_s, busy_s, done_s, eb_s, eop_s, rd_s;
    logic [AW-1:0]   ptr_s, addr_s;
    logic [CW-1:0]   rdata_s;

    logic [CW-1:0]   tape [0:DEPTH-1];

    data_pointer_unit #(.ADDR_W(AW), .MEM_DEPTH(DEPTH), .STEP_W(STEP), .CELL_W(CW), .SATURATE(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy_w), .cmd_op(cmd_op),
        .cmd_off(cmd_off), .scan_abort(scan_abort), .err_clr(err_clr), .ptr(ptr_w), .busy(busy_w),
        .done(done_w), .err_bound(eb_w), .err_op(eop_w), .mem_rd_en(rd_w), .mem_rd_addr(addr_w),
        .mem_rd_data(rdata_w)
    );

    data_pointer_unit #(.ADDR_W(AW), .MEM_DEPTH(DEPTH), .STEP_W(STEP), .CELL_W(CW), .SATURATE(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy_s), .cmd_op(cmd_op),
        .cmd_off(cmd_off), .scan_abort(scan_abort), .err_clr(err_clr), .ptr(ptr_s), .busy(busy_s),
        .done(done_s), .err_bound(eb_s), .err_op(eop_s), .mem_rd_en(rd_s), .mem_rd_addr(addr_s),
        .mem_rd_data(rdata_s)
    );

    // Synchronous-read RAM model: data one cycle after the strobe.
    always @(posedge clk) begin
        if (rd_w) rdata_w <= tape[addr_w];
        if (rd_s) rdata_s <= tape[addr_s];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] op;
        int         off;
        logic       clr;
        int         exp_w;
        int         exp_s;
        logic       eb;
        logic       eop;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic [1:0] op, input int off, input logic clr,
                        input int ew, input int es, input logic eb, input logic eop);
        vec_t v;
        v.op = op; v.off = off; v.clr = clr;
        v.exp_w = ew; v.exp_s = es; v.eb = eb; v.eop = eop;
        vecs.push_back(v);
    endtask

    task automatic issue(input logic [1:0] op, input int off);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_off   = STEP'(off);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Watches both instances from the cycle after the handshake; -1 means no done within budget.
    task automatic wait_done(input int budget, output int dw, output int ds, output int rdn);
        int cyc;
        cyc = 0; dw = -1; ds = -1; rdn = 0;
        forever begin
            if (rd_w) rdn++;
            if (done_w && dw < 0) dw = cyc;
            if (done_s && ds < 0) ds = cyc;
            if ((dw >= 0 && ds >= 0) || cyc >= budget) break;
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int dw, ds, rdn;

        cmd_valid = 1'b0; cmd_op = MOVE; cmd_off = '0; scan_abort = 1'b0; err_clr = 1'b0;
        for (int i = 0; i < DEPTH; i++) tape[i] = 8'd1;
        tape[0] = 8'd7; tape[1] = 8'd7; tape[2] = 8'd7; tape[3] = 8'd0;

        addv(MOVE,    5, 0,    5,    5, 0, 0);
        addv(MOVE,   -3, 0,    2,    2, 0, 0);
        addv(MOVE,   -5, 0, 1021,    0, 1, 0);
        addv(HOME,    0, 0,    0,    0, 1, 0);
        addv(MOVE,  100, 1,  100,  100, 0, 0);
        addv(MOVE, -128, 0,  996,    0, 1, 0);
        addv(MOVE,   26, 0, 1022,   26, 1, 0);
        addv(MOVE,    4, 0,    2,   30, 1, 0);
        addv(RSVD,    9, 0,    2,   30, 1, 1);
        addv(MOVE,    0, 1,    2,   30, 0, 0);
        addv(HOME,    0, 0,    0,    0, 0, 0);
        addv(MOVE,   -1, 0, 1023,    0, 1, 0);
        addv(MOVE,   -1, 1, 1022,    0, 1, 0);
        addv(HOME,    0, 1,    0,    0, 0, 0);
        for (int k = 1; k <= 8; k++) addv(MOVE, 127, 0, 127 * k, 127 * k, 0, 0);
        addv(MOVE,    4, 0, 1020, 1020, 0, 0);
        addv(MOVE,   10, 0,    6, 1023, 1, 0);
        addv(MOVE,   -1, 1,    5, 1022, 0, 0);
        addv(RSVD,   -7, 1,    5, 1022, 0, 1);
        addv(HOME,    0, 1,    0,    0, 0, 0);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst ptr_w", ptr_w, 0);
        chk("rst ptr_s", ptr_s, 0);
        chk("rst done", done_w, 0);
        chk("rst busy", busy_w, 0);
        chk("rst ready", rdy_w, 1);
        chk("rst rd_en", rd_w, 0);
        chk("rst errs", {eb_w, eop_w, eb_s, eop_s}, 0);

        foreach (vecs[i]) begin
            cmd_valid = 1'b1;
            cmd_op    = vecs[i].op;
            cmd_off   = STEP'(vecs[i].off);
            err_clr   = vecs[i].clr;
            @(negedge clk);
            chk($sformatf("v%0d ptr_w", i), ptr_w, vecs[i].exp_w);
            chk($sformatf("v%0d ptr_s", i), ptr_s, vecs[i].exp_s);
            chk($sformatf("v%0d done", i), {done_w, done_s}, 3);
            chk($sformatf("v%0d eb_w", i), eb_w, 0);
            chk($sformatf("v%0d eb_s", i), eb_s, vecs[i].eb);
            chk($sformatf("v%0d eop", i), {eop_w, eop_s}, vecs[i].eop ? 3 : 0);
        end
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
        @(negedge clk);
        chk("idle done", done_w, 0);
        chk("idle ready", rdy_w, 1);

`ifdef DPU_SCAN_EN
        issue(SCAN, 1);
        wait_done(50, dw, ds, rdn);
        chk("scan1 cycles_w", dw, 8);
        chk("scan1 cycles_s", ds, 8);
        chk("scan1 rd_count", rdn, 4);
        chk("scan1 ptr_w", ptr_w, 3);
        chk("scan1 ptr_s", ptr_s, 3);
        chk("scan1 busy", busy_w, 0);
        chk("scan1 errs", {eb_w, eop_w, eb_s, eop_s}, 0);

        issue(HOME, 0);
        issue(SCAN, -1);
        wait_done(3000, dw, ds, rdn);
        chk("scan2 cycles_s", ds, 2);
        chk("scan2 cycles_w", dw, 2044);
        chk("scan2 ptr_w", ptr_w, 3);
        chk("scan2 ptr_s", ptr_s, 0);
        chk("scan2 eb_s", eb_s, 1);
        chk("scan2 eb_w", eb_w, 0);

        err_clr = 1'b1;
        issue(HOME, 0);
        err_clr = 1'b0;
        issue(SCAN, 0);
        wait_done(20, dw, ds, rdn);
        chk("scan0 cycles", dw, 2);
        chk("scan0 ptr", ptr_w, 0);
        chk("scan0 eb_s", eb_s, 0);

        tape[3] = 8'd5;
        issue(SCAN, 1);
        @(negedge clk);
        chk("abort busy", busy_w, 1);
        scan_abort = 1'b1;
        @(negedge clk);
        scan_abort = 1'b0;
        chk("abort ptr_w", ptr_w, 0);
        chk("abort ptr_s", ptr_s, 0);
        chk("abort done", done_w, 1);
        chk("abort busy", busy_w, 0);
        chk("abort ready", rdy_w, 1);
        chk("abort errs", {eb_w, eop_w, eb_s, eop_s}, 0);

        scan_abort = 1'b1;
        issue(MOVE, 1);
        scan_abort = 1'b0;
        chk("idle abort ptr", ptr_w, 1);
        chk("idle abort done", done_w, 1);

        issue(SCAN, 1);
        repeat (4) @(negedge clk);
        chk("midscan busy", busy_w, 1);
        chk("midscan ptr", ptr_w, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst ptr_w", ptr_w, 0);
        chk("arst ptr_s", ptr_s, 0);
        chk("arst busy", busy_w, 0);
        chk("arst rd_en", rd_w, 0);
        chk("arst done", done_w, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post rst ready", rdy_w, 1);
        chk("post rst ptr", ptr_w, 0);
`else
        issue(MOVE, 4);
        issue(SCAN, 3);
        chk("noscan ptr", ptr_w, 4);
        chk("noscan eop", eop_w, 1);
        chk("noscan done", done_w, 1);
        chk("noscan busy", busy_w, 0);
        chk("noscan rd_en", rd_w, 0);
        chk("noscan eb", eb_w, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
